// File: rtl/data_c_pipe_sync_stage.sv
// Registered valid/ready pipeline slice with a skid register; a side-band word
// travels with each stream beat. Forward and backward paths are both registered.
module data_c_pipe_sync_stage #(
  parameter int INF_DSIZE = 32,
  parameter int DSIZE     = 32
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_inf_valid,
  input  logic [INF_DSIZE-1:0] in_inf_data,
  output logic                 in_inf_ready,
  input  logic [DSIZE-1:0]     in_data,
  output logic                 out_inf_valid,
  output logic [INF_DSIZE-1:0] out_inf_data,
  input  logic                 out_inf_ready,
  output logic [DSIZE-1:0]     out_data
);

  logic                 m_valid_r, m_valid_s;
  logic [INF_DSIZE-1:0] m_data_r, m_data_s;
  logic [DSIZE-1:0]     m_side_r, m_side_s;
  logic                 s_valid_r, s_valid_s;
  logic [INF_DSIZE-1:0] s_data_r, s_data_s;
  logic [DSIZE-1:0]     s_side_r, s_side_s;
  logic                 ready_r;
  logic                 in_xfer_s;
  logic                 out_xfer_s;

  assign in_xfer_s  = in_inf_valid & ready_r;
  assign out_xfer_s = m_valid_r & out_inf_ready;

  // Next-state selection: skid drains first so arrival order is preserved.
  always_comb begin
    m_valid_s = m_valid_r;
    m_data_s  = m_data_r;
    m_side_s  = m_side_r;
    s_valid_s = s_valid_r;
    s_data_s  = s_data_r;
    s_side_s  = s_side_r;
    if (!m_valid_r || out_xfer_s) begin
      if (s_valid_r) begin
        m_valid_s = 1'b1;
        m_data_s  = s_data_r;
        m_side_s  = s_side_r;
        if (in_xfer_s) begin
          s_valid_s = 1'b1;
          s_data_s  = in_inf_data;
          s_side_s  = in_data;
        end else begin
          s_valid_s = 1'b0;
        end
      end else if (in_xfer_s) begin
        m_valid_s = 1'b1;
        m_data_s  = in_inf_data;
        m_side_s  = in_data;
      end else begin
        m_valid_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      s_valid_s = 1'b1;
      s_data_s  = in_inf_data;
      s_side_s  = in_data;
    end else begin
      s_valid_s = s_valid_r;
    end
  end

  // State registers; ready is kept separate so it stays low throughout reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_side_r  <= '0;
      s_valid_r <= 1'b0;
      s_data_r  <= '0;
      s_side_r  <= '0;
      ready_r   <= 1'b0;
    end else begin
      m_valid_r <= m_valid_s;
      m_data_r  <= m_data_s;
      m_side_r  <= m_side_s;
      s_valid_r <= s_valid_s;
      s_data_r  <= s_data_s;
      s_side_r  <= s_side_s;
      ready_r   <= ~s_valid_s;
    end
  end

  assign in_inf_ready  = ready_r;
  assign out_inf_valid = m_valid_r;
  assign out_inf_data  = m_data_r;
  assign out_data      = m_side_r;

endmodule

// File: tb/tb_data_c_pipe_sync_stage.sv
// Scoreboard bench for data_c_pipe_sync_stage: stimulus pushes expected beats,
// a negedge monitor pops and compares, plus a 4-stage cascade check.
module tb_data_c_pipe_sync_stage;

  logic        clock;
  logic        rst_n;
  logic        in_inf_valid;
  logic [31:0] in_inf_data;
  logic        in_inf_ready;
  logic [31:0] in_data;
  logic        out_inf_valid;
  logic [31:0] out_inf_data;
  logic        out_inf_ready;
  logic [31:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb[$];
  int epoch = 0;

  data_c_pipe_sync_stage #(.INF_DSIZE(32), .DSIZE(32)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_inf_valid(in_inf_valid), .in_inf_data(in_inf_data), .in_inf_ready(in_inf_ready),
    .in_data(in_data),
    .out_inf_valid(out_inf_valid), .out_inf_data(out_inf_data), .out_inf_ready(out_inf_ready),
    .out_data(out_data)
  );

  // Cascade of four stages
  logic        c0_valid;
  logic [31:0] c0_data, c0_side;
  logic        iv [0:3];
  logic [31:0] id [0:3];
  logic [31:0] is [0:3];
  logic        ordy [0:3];
  logic        sv [0:3];
  logic [31:0] sd [0:3];
  logic [31:0] ss [0:3];
  logic        sr [0:3];

  for (genvar g = 0; g < 4; g++) begin : g_cas
    if (g == 0) begin : g_first
      assign iv[g] = c0_valid;
      assign id[g] = c0_data;
      assign is[g] = c0_side;
    end else begin : g_next
      assign iv[g] = sv[g-1];
      assign id[g] = sd[g-1];
      assign is[g] = ss[g-1];
    end
    if (g == 3) begin : g_last
      assign ordy[g] = 1'b1;
    end else begin : g_mid
      assign ordy[g] = sr[g+1];
    end
    data_c_pipe_sync_stage #(.INF_DSIZE(32), .DSIZE(32)) u_stage (
      .clock(clock), .rst_n(rst_n),
      .in_inf_valid(iv[g]), .in_inf_data(id[g]), .in_inf_ready(sr[g]),
      .in_data(is[g]),
      .out_inf_valid(sv[g]), .out_inf_data(sd[g]), .out_inf_ready(ordy[g]),
      .out_data(ss[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge rst_n) epoch = epoch + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each output transfer, stability while stalled
  logic        hold;
  logic [63:0] held;
  int          hold_epoch;
  initial hold = 1'b0;
  always @(negedge clock) begin
    if (rst_n) begin
      if (hold && hold_epoch == epoch) begin
        chk("stall_valid", {63'd0, out_inf_valid}, 64'd1);
        chk("stall_beat", {out_inf_data, out_data}, held);
      end
      if (out_inf_valid && out_inf_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", {out_inf_data, out_data});
        end else begin
          chk("scoreboard", {out_inf_data, out_data}, sb.pop_front());
        end
      end
      hold       = out_inf_valid && !out_inf_ready;
      held       = {out_inf_data, out_data};
      hold_epoch = epoch;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [31:0] s, output int waited);
    waited       = 0;
    in_inf_valid = 1'b1;
    in_inf_data  = d;
    in_data      = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_inf_ready) begin
        sb.push_back({d, s});
        @(posedge clock);
        #1;
        in_inf_valid = 1'b0;
        return;
      end
      waited++;
      @(posedge clock);
      #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: got no ready expected ready for %h", d);
    in_inf_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    out_inf_ready = 1'b1;
    in_inf_valid  = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int sent;
    int cyc;
    bit acc;
    rst_n = 1'b0; in_inf_valid = 1'b1; in_inf_data = 32'h99; in_data = 32'h66;
    out_inf_ready = 1'b1; c0_valid = 1'b0; c0_data = 32'd0; c0_side = 32'd0;

    // Reset holds outputs low regardless of input activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_out_valid", {63'd0, out_inf_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_inf_ready}, 64'd0);
    end
    @(posedge clock); #1;
    rst_n = 1'b1; in_inf_valid = 1'b0;
    chk("rst_out_data", {out_inf_data, out_data}, 64'd0);

    send(32'h11, 32'hA5, w);
    chk("single_valid", {63'd0, out_inf_valid}, 64'd1);
    chk("single_beat", {out_inf_data, out_data}, {32'h11, 32'hA5});

    // Streaming at full rate
    for (int n = 0; n < 16; n++) begin
      send(32'(n), 32'h100 + 32'(n), w);
      chk("stream_ready_high", 64'(w), 64'd0);
      chk("stream_latency", {31'd0, out_inf_valid, out_inf_data, out_data},
          {31'd0, 1'b1, 32'(n), 32'h100 + 32'(n)});
    end
    @(posedge clock); #1;
    drain("stream_drain");

    // Backpressure and skid
    out_inf_ready = 1'b0;
    send(32'd1, 32'hB1, w);
    chk("bp_beat1_accept", 64'(w), 64'd0);
    send(32'd2, 32'hB2, w);
    chk("bp_beat2_accept", 64'(w), 64'd0);
    in_inf_valid = 1'b1; in_inf_data = 32'd3; in_data = 32'hB3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_ready_low", {63'd0, in_inf_ready}, 64'd0);
      chk("bp_out_hold", {out_inf_data, out_data}, {32'd1, 32'hB1});
      @(posedge clock); #1;
    end
    out_inf_ready = 1'b1;
    send(32'd3, 32'hB3, w);
    drain("bp_drain");

    // Random valid/ready
    sent = 0; cyc = 0; in_inf_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_inf_ready = 1'($urandom_range(0, 1));
      if (!in_inf_valid) begin
        in_inf_data = $urandom;
        in_data     = $urandom;
        if ($urandom_range(0, 1) == 1) in_inf_valid = 1'b1;
      end
      @(negedge clock);
      acc = in_inf_valid && in_inf_ready;
      if (acc) sb.push_back({in_inf_data, in_data});
      @(posedge clock); #1;
      if (acc) begin
        in_inf_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", 64'(sent), 64'd1000);
    drain("rand_drain");

    // Reset mid-flight discards held beats immediately
    out_inf_ready = 1'b0;
    send(32'hD1, 32'hE1, w);
    send(32'hD2, 32'hE2, w);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_inf_valid}, 64'd0);
    chk("midrst_ready", {63'd0, in_inf_ready}, 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    out_inf_ready = 1'b1;
    send(32'h5A, 32'hC3, w);
    chk("midrst_next_beat", {out_inf_data, out_data}, {32'h5A, 32'hC3});
    drain("midrst_drain");
    repeat (3) @(posedge clock);
    #1;

    // Cascade: beat ripples one stage per cycle
    c0_valid = 1'b1; c0_data = 32'h55; c0_side = 32'h77;
    @(posedge clock); #1;
    c0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("cas_stage_valid", {63'd0, sv[k]}, 64'd1);
      chk("cas_stage_side", 64'(ss[k]), 64'h77);
      if (k < 3) chk("cas_last_not_yet", {63'd0, sv[3]}, 64'd0);
      @(posedge clock); #1;
    end
    chk("cas_last_data", 64'(sd[3]), 64'h55);
    chk("cas_last_gone", {63'd0, sv[3]}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
